// File: rtl/add_bit_pkg.sv
// Shared constants for the add_bit leaf arithmetic cell.
package add_bit_pkg;

    // Value both output registers take while reset is asserted.
    localparam logic ADD_BIT_RST_VAL = 1'b0;

endpackage : add_bit_pkg

// File: rtl/add_bit_cell.sv
// Pure combinational full adder: s = a ^ b ^ ci, co = majority(a, b, ci).
module add_bit_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : add_bit_cell

// File: rtl/add_bit.sv
// Full adder with a registered output stage and an optional bit-serial
// carry loop closed through the cout_q flop.
module add_bit
    import add_bit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic en,
    input  logic serial,
    output logic sum,
    output logic cout,
    output logic sum_q,
    output logic cout_q
);

    logic c_eff;

    // In serial mode the carry comes from our own registered carry-out; the
    // flop breaks the loop, so there is no combinational cycle.
    assign c_eff = serial ? cout_q : cin;

    add_bit_cell u_cell (
        .a  (a),
        .b  (b),
        .ci (c_eff),
        .s  (sum),
        .co (cout)
    );

    // Output registers: async clear, load on enable, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values; blocking here would race with other readers.
            sum_q  <= ADD_BIT_RST_VAL;
            cout_q <= ADD_BIT_RST_VAL;
        end else if (en) begin
            sum_q  <= sum;
            cout_q <= cout;
        end
    end

endmodule : add_bit

// File: tb/tb_add_bit.sv
// Directed self-checking bench for add_bit.
module tb_add_bit;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst, a, b, cin, en, serial;
    logic sum, cout, sum_q, cout_q;

    int n_cmp = 0;
    int n_err = 0;

    add_bit dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .en     (en),
        .serial (serial),
        .sum    (sum),
        .cout   (cout),
        .sum_q  (sum_q),
        .cout_q (cout_q)
    );

    // Clock only toggles once a test enables it.
    always #5 if (clk_run) clk = ~clk;

    // Wait for a rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Test 1: combinational full adder with the clock stopped.
    task automatic test_comb();
        logic [1:0] ab_seq [6];
        logic [1:0] exp0   [6];
        logic [1:0] exp1   [6];
        ab_seq = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11};
        exp0   = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
        exp1   = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
        rst = 1'b0; serial = 1'b0; en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 6; i++) begin
                logic [1:0] ab;
                logic [1:0] exp_cs;
                ab = ab_seq[i];
                exp_cs = (c == 0) ? exp0[i] : exp1[i];
                a = ab[1]; b = ab[0]; cin = c[0];
                #2;
                n_cmp++;
                if ({cout, sum} !== exp_cs) begin
                    n_err++;
                    $display("FAIL comb cin=%0d ab=%b: cout,sum=%b expected %b",
                             c, ab, {cout, sum}, exp_cs);
                end
            end
        end
    endtask

    // Reset state: both registers clear with reset asserted.
    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({sum_q, cout_q} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_state: sum_q,cout_q=%b expected 00", {sum_q, cout_q});
        end
        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Test 2: load on enable, then hold with enable low.
    task automatic test_register();
        serial = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
        tick();
        n_cmp++;
        if ({sum_q, cout_q} !== 2'b11) begin
            n_err++;
            $display("FAIL reg_load: sum_q,cout_q=%b expected 11", {sum_q, cout_q});
        end
        en = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({sum_q, cout_q} !== 2'b11) begin
            n_err++;
            $display("FAIL reg_hold: sum_q,cout_q=%b expected 11", {sum_q, cout_q});
        end
    endtask

    // Test 3: async clear between edges; no load while reset is high.
    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({sum_q, cout_q} !== 2'b00) begin
            n_err++;
            $display("FAIL async_clear: sum_q,cout_q=%b expected 00", {sum_q, cout_q});
        end
        en = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1; serial = 1'b0;
        tick();
        n_cmp++;
        if ({sum_q, cout_q} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_dominates_en: sum_q,cout_q=%b expected 00", {sum_q, cout_q});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({sum_q, cout_q} !== 2'b11) begin
            n_err++;
            $display("FAIL load_after_release: sum_q,cout_q=%b expected 11", {sum_q, cout_q});
        end
    endtask

    // Test 4: 4-bit serial add 1011 + 0110 = 1_0001.
    task automatic test_serial();
        logic [3:0] op_a;
        logic [3:0] op_b;
        logic [3:0] exp_s;
        op_a = 4'b1011; op_b = 4'b0110; exp_s = 4'b0001;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; serial = 1'b1; en = 1'b1; cin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = op_a[i]; b = op_b[i];
            tick();
            n_cmp++;
            if (sum_q !== exp_s[i]) begin
                n_err++;
                $display("FAIL serial_bit%0d: sum_q=%b expected %b", i, sum_q, exp_s[i]);
            end
        end
        n_cmp++;
        if (cout_q !== 1'b1) begin
            n_err++;
            $display("FAIL serial_carry_out: cout_q=%b expected 1", cout_q);
        end
        // Hold with enable low even though the loop would change state.
        en = 1'b0; a = 1'b1; b = 1'b1;
        tick();
        n_cmp++;
        if ({sum_q, cout_q} !== 2'b01) begin
            n_err++;
            $display("FAIL serial_hold: sum_q,cout_q=%b expected 01", {sum_q, cout_q});
        end
    endtask

    // Test 5: serial mode uses cout_q and ignores cin; switching mode is immediate.
    task automatic test_serial_ignores_cin();
        serial = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0;
        #1;
        n_cmp++;
        if ({cout, sum} !== 2'b01) begin
            n_err++;
            $display("FAIL serial_ignores_cin: cout,sum=%b expected 01", {cout, sum});
        end
        serial = 1'b0;
        #1;
        n_cmp++;
        if ({cout, sum} !== 2'b00) begin
            n_err++;
            $display("FAIL mode_switch: cout,sum=%b expected 00", {cout, sum});
        end
    endtask

    // Test 6: reset mid-stream drops the carry; next bit adds with carry 0.
    task automatic test_reset_mid_stream();
        logic [3:0] op_a;
        logic [3:0] op_b;
        op_a = 4'b1011; op_b = 4'b0110;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; serial = 1'b1; en = 1'b1; cin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = op_a[i]; b = op_b[i];
            tick();
        end
        n_cmp++;
        if (cout_q !== 1'b1) begin
            n_err++;
            $display("FAIL midstream_carry_before: cout_q=%b expected 1", cout_q);
        end
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a = 1'b1; b = 1'b0;
        #1;
        n_cmp++;
        if ({cout, sum} !== 2'b01) begin
            n_err++;
            $display("FAIL midstream_after_reset: cout,sum=%b expected 01", {cout, sum});
        end
        tick();
        n_cmp++;
        if ({sum_q, cout_q} !== 2'b10) begin
            n_err++;
            $display("FAIL midstream_registered: sum_q,cout_q=%b expected 10", {sum_q, cout_q});
        end
    endtask

    initial begin
        rst = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0; en = 1'b0; serial = 1'b0;
        test_comb();
        test_reset();
        test_register();
        test_async_reset();
        test_serial();
        test_serial_ignores_cin();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_add_bit

// File: doc/add_bit.md
# add_bit

Single-bit full adder with a registered output stage and an optional bit-serial carry loop. It is the leaf arithmetic cell of the datapath. With `serial` low it behaves as a pure combinational full adder that is usable without a clock. With `serial` high it feeds back its own registered carry, so a stream of operand bits applied LSB-first forms a bit-serial adder.

## Interface
Parameters: none.

Clock and reset: one clock; reset is asynchronous and active-high.

Ports:
- `clk`  in  1  rising-edge clock for the register stage
- `rst`  in  1  asynchronous, active-high reset; clears all registers
- `a`  in  1  operand bit A
- `b`  in  1  operand bit B
- `cin`  in  1  external carry-in; used when `serial`=0
- `en`  in  1  register load enable
- `serial`  in  1  1 = carry-in taken from `cout_q`, 0 = from `cin`
- `sum`  out  1  combinational sum bit
- `cout`  out  1  combinational carry-out bit
- `sum_q`  out  1  registered `sum`
- `cout_q`  out  1  registered `cout`; this is also the serial carry state

## Operation
- Effective carry: `c_eff = serial ? cout_q : cin`.
- `sum = a ^ b ^ c_eff`.
- `cout = (a & b) | (a & c_eff) | (b & c_eff)`.
- With `serial`=0, `sum` and `cout` depend only on `a`, `b` and `cin`. They are correct even if `clk` never toggles and `rst` is held low or is undriven-low.
- Register stage, on rising `clk`:
  - if `en`=1: `sum_q <= sum`, `cout_q <= cout`;
  - if `en`=0: both registers hold.
- Bit-serial use:
  - Assert `rst` (or load a 0 carry) to start.
  - Set `serial`=1 and `en`=1.
  - Apply A[i], B[i] LSB-first, one bit per cycle.
  - `sum_q` delivers S[i] one cycle after the bit is applied.
  - After the last bit, `cout_q` holds the final carry-out.
- Changing `serial` mid-stream is legal. It takes effect combinationally on the next evaluation of `c_eff`.

## Timing
- `sum` and `cout`: zero-cycle combinational path from `a`, `b`, `cin`, `serial` and `cout_q`.
- `sum_q` and `cout_q`: one-cycle latency from their inputs; they update only on rising `clk` with `en`=1.
- Reset:
  - `rst`=1 forces `sum_q`=0 and `cout_q`=0 immediately, independent of `clk`.
  - Reset dominates `en` when both are asserted.
  - Release of `rst` is synchronous to the first following rising `clk`; no load occurs on the edge where `rst` is still high.
- Reset mid-stream: the serial carry is lost (`cout_q`=0). The next bit is added with carry 0.
- No combinational loop exists: the feedback path goes through the `cout_q` flop.

## Structure
- Sub-module `add_bit_cell`: pure combinational full adder (a, b, ci -> s, co), instantiated once.
- The top level contains the `c_eff` mux and the two flops with enable and async reset.
- No shared-package content is required, except a package constant `ADD_BIT_RST_VAL = 1'b0` for the register reset value.

## Test plan
1. Combinational truth table, `serial`=0, no clock:
   - `cin`=0 and (a,b) swept through 00,10,00,01,00,11 -> (cout,sum) = 00,01,00,01,00,10.
   - Repeat with `cin`=1 -> 01,10,01,10,01,11.
2. Register stage, `serial`=0, `en`=1, a=1, b=1, `cin`=1, one `clk` edge -> `sum_q`=1, `cout_q`=1. Then `en`=0 with a=0 -> registers hold 1,1.
3. Async reset: with `sum_q`=`cout_q`=1, pulse `rst` between clock edges -> both read 0 immediately. A clock edge while `rst`=1 does not load.
4. Bit-serial, `serial`=1, `en`=1, after reset, A=4'b1011, B=4'b0110 applied LSB-first:
   - `sum_q` sequence is 1,0,0,0 (S=0001);
   - final `cout_q`=1 (total 17).
5. Serial carry ignores `cin`: `serial`=1, `cout_q`=1, a=0, b=0, `cin`=0 -> `sum`=1, `cout`=0.
6. Reset mid-stream: in scenario 4, assert `rst` after bit 1 while `cout_q`=1 -> the next bit uses carry 0. For a=1, b=0 this gives `sum`=1, `cout`=0.
